gshare_predictor_spec: RTL and testbench

//  Parametrised successor to the CPU's gshare branch predictor. Fetch-side prediction port plus an

---
 rtl/gshare_predictor_spec.sv | 156 +++++++++++++++
 tb/tb_gshare_predictor_spec.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor_spec.sv
// gshare branch predictor with speculative global history and history repair.
// Counter table is swept to weakly-not-taken after every reset.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   ready               high once the init sweep has finished
//   pred_req, pred_pc   fetch-side prediction request
//   pred_valid          one-cycle pulse, one cycle after an accepted request
//   pred_taken          predicted direction (counter MSB)
//   pred_hist           speculative history used for that prediction
//   upd_en, upd_pc      execute-side resolved-branch update
//   upd_hist            pred_hist that travelled with the branch
//   upd_taken           actual outcome
//   upd_mispredict      outcome differed from prediction; repair history
module gshare_predictor_spec #(
    parameter int HIST_LEN = 8,
    parameter int IDX_W    = 8,
    parameter int CTR_W    = 2,
    parameter int PC_W     = 32,
    parameter int PC_LSB   = 2
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ready,
    input  logic                pred_req,
    input  logic [PC_W-1:0]     pred_pc,
    output logic                pred_valid,
    output logic                pred_taken,
    output logic [HIST_LEN-1:0] pred_hist,
    input  logic                upd_en,
    input  logic [PC_W-1:0]     upd_pc,
    input  logic [HIST_LEN-1:0] upd_hist,
    input  logic                upd_taken,
    input  logic                upd_mispredict
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_MIN = '0;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [IDX_W-1:0]    sweep_idx;
    logic [HIST_LEN-1:0] spec_hist;
    logic [CTR_W-1:0]    ctr_mem [DEPTH];

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             pred_fire;
    logic             upd_fire;
    logic             pred_bit;
    logic [CTR_W-1:0] upd_cur;
    logic [CTR_W-1:0] upd_next;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [CTR_W-1:0] wr_data;

    // Only the index bits of the PCs matter; the rest are deliberately dropped.
    logic unused_pc;
    assign unused_pc = ^{pred_pc, upd_pc};

    // Bitwise form of XOR-ing IDX_W-bit chunks; a short final chunk is
    // effectively zero-extended because its missing bits contribute nothing.
    function automatic logic [IDX_W-1:0] fold(input logic [HIST_LEN-1:0] h);
        logic [IDX_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < HIST_LEN; i++) begin
            acc[i % IDX_W] = acc[i % IDX_W] ^ h[i];
        end
        return acc;
    endfunction

    assign pred_idx = pred_pc[PC_LSB +: IDX_W] ^ fold(spec_hist);
    assign upd_idx  = upd_pc[PC_LSB +: IDX_W] ^ fold(upd_hist);

    assign ready     = (state == S_RUN);
    assign pred_fire = ready & pred_req;
    assign upd_fire  = ready & upd_en;

    // Read happens before the same-edge write, so a colliding update is
    // not visible to the prediction made on that edge.
    assign pred_bit = ctr_mem[pred_idx][CTR_W-1];
    assign upd_cur  = ctr_mem[upd_idx];

    always_comb begin
        upd_next = upd_cur;
        if (upd_taken) begin
            if (upd_cur != CTR_MAX) upd_next = upd_cur + CTR_W'(1);
        end else begin
            if (upd_cur != CTR_MIN) upd_next = upd_cur - CTR_W'(1);
        end
    end

    // Single write port shared by the init sweep and training updates.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = sweep_idx;
        wr_data = WNT;
        if (!reset) begin
            if (state == S_INIT) begin
                wr_en = 1'b1;
            end else if (upd_fire) begin
                wr_en   = 1'b1;
                wr_idx  = upd_idx;
                wr_data = upd_next;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_INIT: if (&sweep_idx) state_nx = S_RUN;
            S_RUN:  state_nx = S_RUN;
            default: state_nx = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_INIT;
            sweep_idx  <= '0;
            spec_hist  <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_hist  <= '0;
        end else begin
            state      <= state_nx;
            pred_valid <= pred_fire;
            if (state == S_INIT) sweep_idx <= sweep_idx + IDX_W'(1);
            if (pred_fire) begin
                pred_taken <= pred_bit;
                pred_hist  <= spec_hist;
            end
            // Repair wins over the speculative shift on the same edge.
            if (upd_fire && upd_mispredict) begin
                spec_hist <= {upd_hist[HIST_LEN-2:0], upd_taken};
            end else if (pred_fire) begin
                spec_hist <= {spec_hist[HIST_LEN-2:0], pred_bit};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) ctr_mem[wr_idx] <= wr_data;
    end

endmodule

// File: tb/tb_gshare_predictor_spec.sv
// Directed bench for gshare_predictor_spec (CTR_W=2 main DUT, CTR_W=3 variant).
// Expected values are hand-computed from the index/history rules.
module tb_gshare_predictor_spec;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [7:0]  pred_hist;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic [7:0]  upd_hist;
    logic        upd_taken;
    logic        upd_mispredict;

    logic        ready3;
    logic        pred_req3;
    logic [31:0] pred_pc3;
    logic        pred_valid3;
    logic        pred_taken3;
    logic [7:0]  pred_hist3;
    logic        upd_en3;
    logic [31:0] upd_pc3;
    logic [7:0]  upd_hist3;
    logic        upd_taken3;
    logic        upd_mispredict3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gshare_predictor_spec dut (
        .clk(clk), .reset(reset), .ready(ready),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_hist(pred_hist),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_hist(upd_hist),
        .upd_taken(upd_taken), .upd_mispredict(upd_mispredict)
    );

    gshare_predictor_spec #(.CTR_W(3)) dut3 (
        .clk(clk), .reset(reset), .ready(ready3),
        .pred_req(pred_req3), .pred_pc(pred_pc3),
        .pred_valid(pred_valid3), .pred_taken(pred_taken3),
        .pred_hist(pred_hist3),
        .upd_en(upd_en3), .upd_pc(upd_pc3), .upd_hist(upd_hist3),
        .upd_taken(upd_taken3), .upd_mispredict(upd_mispredict3)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end at a falling edge.
    task automatic predict(input string tag, input logic [31:0] pc,
                           input logic t, input logic [7:0] h);
        pred_req = 1'b1;
        pred_pc  = pc;
        @(negedge clk);
        pred_req = 1'b0;
        chk({tag, "_v"}, 32'(pred_valid), 32'd1);
        chk(tag, 32'(pred_taken), 32'(t));
        chk({tag, "_h"}, 32'(pred_hist), 32'(h));
    endtask

    task automatic update(input logic [31:0] pc, input logic [7:0] h,
                          input logic t, input logic mis);
        upd_en         = 1'b1;
        upd_pc         = pc;
        upd_hist       = h;
        upd_taken      = t;
        upd_mispredict = mis;
        @(negedge clk);
        upd_en         = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic predict3(input string tag, input logic [31:0] pc,
                            input logic t);
        pred_req3 = 1'b1;
        pred_pc3  = pc;
        @(negedge clk);
        pred_req3 = 1'b0;
        chk({tag, "_v"}, 32'(pred_valid3), 32'd1);
        chk(tag, 32'(pred_taken3), 32'(t));
    endtask

    task automatic update3(input logic [31:0] pc, input logic t,
                           input logic mis);
        upd_en3         = 1'b1;
        upd_pc3         = pc;
        upd_hist3       = 8'h00;
        upd_taken3      = t;
        upd_mispredict3 = mis;
        @(negedge clk);
        upd_en3         = 1'b0;
        upd_mispredict3 = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int exp);
        int n;
        n = 0;
        while (!ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n), 32'(exp));
    endtask

    initial begin
        reset = 1'b1;
        pred_req = 1'b0; pred_pc = '0;
        upd_en = 1'b0; upd_pc = '0; upd_hist = '0;
        upd_taken = 1'b0; upd_mispredict = 1'b0;
        pred_req3 = 1'b0; pred_pc3 = '0;
        upd_en3 = 1'b0; upd_pc3 = '0; upd_hist3 = '0;
        upd_taken3 = 1'b0; upd_mispredict3 = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_valid", 32'(pred_valid), 32'd0);
        chk("rst_taken", 32'(pred_taken), 32'd0);
        chk("rst_hist", 32'(pred_hist), 32'd0);
        reset = 1'b0;
        wait_ready("init_len", 256);

        // 1: everything weakly not-taken
        predict("t1_0", 32'h0, 1'b0, 8'h00);
        predict("t1_40", 32'h40, 1'b0, 8'h00);
        predict("t1_3fc", 32'h3FC, 1'b0, 8'h00);
        predict("t1_top", 32'hFFFF_FFFC, 1'b0, 8'h00);

        // 2: idx 0x10 trained 1->2->3
        update(32'h40, 8'h00, 1'b1, 1'b0);
        update(32'h40, 8'h00, 1'b1, 1'b0);
        predict("t2_pred", 32'h40, 1'b1, 8'h00);
        @(negedge clk);
        chk("t2_vlow", 32'(pred_valid), 32'd0);
        chk("t2_hold_t", 32'(pred_taken), 32'd1);
        chk("t2_hold_h", 32'(pred_hist), 32'd0);
        update(32'h3FC, 8'h00, 1'b0, 1'b1);

        // 3: saturation at both ends
        repeat (5) update(32'h40, 8'h00, 1'b1, 1'b0);
        predict("t3_sat3", 32'h40, 1'b1, 8'h00);
        update(32'h3FC, 8'h00, 1'b0, 1'b1);
        update(32'h40, 8'h00, 1'b0, 1'b0);
        predict("t3_c2", 32'h40, 1'b1, 8'h00);
        update(32'h3FC, 8'h00, 1'b0, 1'b1);
        repeat (3) update(32'h40, 8'h00, 1'b0, 1'b0);
        predict("t3_c0", 32'h40, 1'b0, 8'h00);
        update(32'h40, 8'h00, 1'b1, 1'b0);
        predict("t3_c1", 32'h40, 1'b0, 8'h00);
        update(32'h40, 8'h00, 1'b1, 1'b0);
        predict("t3_c2b", 32'h40, 1'b1, 8'h00);
        update(32'h3FC, 8'h00, 1'b0, 1'b1);

        // 4: speculative history and repair
        predict("t4_p1", 32'h40, 1'b1, 8'h00);
        predict("t4_p2", 32'h44, 1'b1, 8'h01);
        predict("t4_p3", 32'h40, 1'b0, 8'h03);
        predict("t4_h6", 32'h0, 1'b0, 8'h06);
        update(32'h3FC, 8'h01, 1'b0, 1'b1);
        predict("t4_rep", 32'h0, 1'b0, 8'h02);
        upd_mispredict = 1'b1;
        upd_hist = 8'hAA;
        upd_taken = 1'b1;
        @(negedge clk);
        upd_mispredict = 1'b0;
        predict("t4_ign", 32'h0, 1'b0, 8'h04);

        // 5: same-edge read/write and repair priority
        pred_req = 1'b1; pred_pc = 32'h80;
        upd_en = 1'b1; upd_pc = 32'hA0; upd_hist = 8'h00;
        upd_taken = 1'b1; upd_mispredict = 1'b0;
        @(negedge clk);
        pred_req = 1'b0; upd_en = 1'b0;
        chk("t5_rbw", 32'(pred_taken), 32'd0);
        chk("t5_rbw_h", 32'(pred_hist), 32'h08);
        predict("t5_later", 32'hE0, 1'b1, 8'h10);
        pred_req = 1'b1; pred_pc = 32'h0;
        upd_en = 1'b1; upd_pc = 32'h3FC; upd_hist = 8'h00;
        upd_taken = 1'b1; upd_mispredict = 1'b1;
        @(negedge clk);
        pred_req = 1'b0; upd_en = 1'b0; upd_mispredict = 1'b0;
        chk("t5_pri_h", 32'(pred_hist), 32'h21);
        predict("t5_pri", 32'h0, 1'b0, 8'h01);

        // 6: reset clears outputs, mid-sweep reset restarts sweep
        update(32'h0, 8'h00, 1'b1, 1'b0);
        update(32'h0, 8'h00, 1'b1, 1'b0);
        predict("t6_pre", 32'h8, 1'b1, 8'h02);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_t", 32'(pred_taken), 32'd0);
        chk("t6_rst_h", 32'(pred_hist), 32'd0);
        chk("t6_rst_r", 32'(ready), 32'd0);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        chk("t6_mid_r", 32'(ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        pred_req = 1'b1; pred_pc = 32'h40;
        upd_en = 1'b1; upd_pc = 32'h40; upd_hist = 8'h00;
        upd_taken = 1'b1; upd_mispredict = 1'b1;
        @(negedge clk);
        pred_req = 1'b0; upd_en = 1'b0; upd_mispredict = 1'b0;
        chk("t6_init_ign", 32'(pred_valid), 32'd0);
        wait_ready("t6_len", 205);
        predict("t6_40", 32'h40, 1'b0, 8'h00);
        predict("t6_3fc", 32'h3FC, 1'b0, 8'h00);
        predict("t6_a0", 32'hA0, 1'b0, 8'h00);
        predict("t6_0", 32'h0, 1'b0, 8'h00);

        // CTR_W=3: init 3, saturates at 7
        chk("c3_ready", 32'(ready3), 32'd1);
        predict3("c3_init", 32'h40, 1'b0);
        update3(32'h40, 1'b1, 1'b0);
        predict3("c3_c4", 32'h40, 1'b1);
        update3(32'h3FC, 1'b0, 1'b1);
        repeat (9) update3(32'h40, 1'b1, 1'b0);
        repeat (3) update3(32'h40, 1'b0, 1'b0);
        predict3("c3_sat", 32'h40, 1'b1);
        update3(32'h3FC, 1'b0, 1'b1);
        update3(32'h40, 1'b0, 1'b0);
        predict3("c3_c3", 32'h40, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
